mux_arb_nx1: RTL and testbench

//  Parametrised N-to-1 registered multiplexer/arbiter, W bits per channel; successor to the fixed-size

---
 rtl/mux_arb_nx1.sv | 73 +++++++
 tb/tb_mux_arb_nx1.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_nx1.sv
// N-to-1 registered multiplexer/arbiter with valid/ready handshakes.
// The grant comes either from sel directly (mode 0) or from a round-robin search (mode 1).
module mux_arb_nx1 #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 4,
  parameter int unsigned SW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] g;
  logic          hit;
  logic          ld;
  int unsigned   rr_idx;

  assign ld = !out_valid || out_ready;

  // Round-robin search visits ptr+1 .. ptr+N with wrap; the first valid channel wins.
  always_comb begin
    g      = '0;
    hit    = 1'b0;
    rr_idx = 0;
    if (!mode) begin
      g = sel;
      if (32'(sel) < N) hit = in_valid[sel];
    end else begin
      for (int unsigned i = 1; i <= N; i++) begin
        rr_idx = 32'(ptr) + i;
        if (rr_idx >= N) rr_idx = rr_idx - N;
        if (!hit && in_valid[rr_idx[SW-1:0]]) begin
          hit = 1'b1;
          g   = rr_idx[SW-1:0];
        end
      end
    end
  end

  // No channel is offered a transfer while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (rst_n && ld && hit) in_ready[g] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SW'(N - 1);
    end else if (ld) begin
      if (hit) begin
        out_data  <= in_data[g*W +: W];
        out_ch    <= g;
        out_valid <= 1'b1;
        if (mode) ptr <= g;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Self-checking bench for mux_arb_nx1 against a behavioural grant/output model.
module tb_mux_arb_nx1;
  localparam int N  = 8;
  localparam int W  = 4;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid;
  logic            out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int         m_ptr   = N - 1;
  bit         m_valid = 0;
  bit [W-1:0] m_data  = '0;
  int         m_ch    = 0;

  mux_arb_nx1 #(.N(N), .W(W), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    m_ptr = N - 1; m_valid = 0; m_data = '0; m_ch = 0;
  endfunction

  function automatic void m_grant(output bit hit, output int g);
    hit = 0; g = 0;
    if (!mode) begin
      g = int'(sel);
      hit = (g < N) && in_valid[g];
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!hit && in_valid[c]) begin hit = 1; g = c; end
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_ready();
    bit hit; int g; logic [N-1:0] r;
    r = '0;
    m_grant(hit, g);
    if (rst_n && (!m_valid || out_ready) && hit) r[g] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    bit hit; int g; bit ld;
    m_grant(hit, g);
    ld = !m_valid || out_ready;
    @(posedge clk);
    if (rst_n && ld) begin
      if (hit) begin
        m_data = in_data[g*W +: W]; m_ch = g; m_valid = 1;
        if (mode) m_ptr = g;
      end else m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; mode = 1; sel = '0; in_valid = '1; out_ready = 1; in_data = 32'h7654_3210;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    n_checks++; if (out_ch !== '0) begin n_fail++; $display("FAIL reset_ch got %0d want 0", out_ch); end
    n_checks++; if (in_ready !== '0) begin n_fail++; $display("FAIL reset_ready got %h want 0", in_ready); end
    rst_n = 1;
    #1;
    n_checks++; if (in_ready !== 8'h01) begin n_fail++; $display("FAIL reset_first_ready got %h want 01", in_ready); end
    tick();
    n_checks++; if (out_ch !== 3'd0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL reset_first_grant got ch%0d v%b want ch0 v1", out_ch, out_valid); end
  endtask

  task automatic test_mode0();
    logic [SW-1:0] sels [2] = '{3'd5, 3'd2};
    @(negedge clk);
    mode = 0; out_ready = 1; in_valid = '1;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(k + 8);
    foreach (sels[i]) begin
      sel = sels[i];
      #1;
      n_checks++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL mode0_ready sel%0d got %h want %h", sel, in_ready, exp_ready()); end
      tick();
      n_checks++; if (out_data !== m_data || out_ch !== SW'(m_ch) || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL mode0_out sel%0d got d%h ch%0d want d%h ch%0d", sel, out_data, out_ch, m_data, m_ch); end
      @(negedge clk);
    end
    n_checks++; if (out_data !== 4'hA || out_ch !== 3'd2) begin n_fail++; $display("FAIL mode0_abs got d%h ch%0d want dA ch2", out_data, out_ch); end
  endtask

  task automatic test_round_robin();
    mode = 1; in_valid = '1; out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      in_data = $urandom();
      #1;
      n_checks++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rr_ready c%0d got %h want %h", c, in_ready, exp_ready()); end
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_ch !== SW'(m_ch) || out_data !== m_data) begin
        n_fail++; $display("FAIL rr_out c%0d got v%b ch%0d d%h want v1 ch%0d d%h", c, out_valid, out_ch, out_data, m_ch, m_data); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_pressure();
    bit [W-1:0] held_d; logic [SW-1:0] held_c;
    mode = 1; in_valid = '1; out_ready = 1; in_data = $urandom();
    tick();
    held_d = out_data; held_c = out_ch;
    @(negedge clk);
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      in_data = $urandom();
      #1;
      n_checks++; if (in_ready !== '0) begin n_fail++; $display("FAIL bp_ready c%0d got %h want 0", c, in_ready); end
      tick();
      n_checks++; if (out_data !== held_d || out_ch !== held_c || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold c%0d got d%h ch%0d want d%h ch%0d", c, out_data, out_ch, held_d, held_c); end
      @(negedge clk);
    end
    out_ready = 1;
    tick();
    n_checks++; if (out_ch !== SW'((int'(held_c) + 1) % N) || out_data !== m_data) begin
      n_fail++; $display("FAIL bp_resume got ch%0d d%h want ch%0d d%h", out_ch, out_data, (int'(held_c) + 1) % N, m_data); end
  endtask

  task automatic test_sparse();
    int want [3] = '{6, 3, 6};
    @(negedge clk);
    mode = 1; out_ready = 1; in_valid = 8'h08; in_data = $urandom();
    tick();
    @(negedge clk);
    in_valid = 8'h48;
    foreach (want[i]) begin
      in_data = $urandom();
      tick();
      n_checks++; if (out_ch !== SW'(want[i]) || out_data !== m_data || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL sparse_grant i%0d got ch%0d d%h want ch%0d d%h", i, out_ch, out_data, want[i], m_data); end
      @(negedge clk);
    end
    in_valid = '0;
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_ch !== 3'd6) begin n_fail++; $display("FAIL sparse_drain got v%b ch%0d want v0 ch6", out_valid, out_ch); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      mode = 1'($urandom()); sel = SW'($urandom()); in_data = $urandom();
      in_valid = N'($urandom() & $urandom()); out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready c%0d got %h want %h", c, in_ready, exp_ready()); end
      tick();
      n_checks++; if (out_valid !== m_valid || (m_valid && (out_ch !== SW'(m_ch) || out_data !== m_data))) begin
        n_fail++; $display("FAIL rand_out c%0d got v%b ch%0d d%h want v%b ch%0d d%h", c, out_valid, out_ch, out_data, m_valid, m_ch, m_data); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    mode = 1; in_valid = '1; out_ready = 1; in_data = $urandom();
    tick();
    @(negedge clk);
    out_ready = 0;
    tick();
    #2;
    rst_n = 0;
    #1;
    m_reset();
    n_checks++; if (out_valid !== 1'b0 || out_ch !== '0 || out_data !== '0) begin
      n_fail++; $display("FAIL async_reset got v%b ch%0d d%h want v0 ch0 d0", out_valid, out_ch, out_data); end
    @(negedge clk);
    rst_n = 1; out_ready = 1; in_data = $urandom();
    tick();
    n_checks++; if (out_ch !== 3'd0 || out_data !== m_data || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL async_reset_prio got ch%0d d%h want ch0 d%h", out_ch, out_data, m_data); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_round_robin();
    test_back_pressure();
    test_sparse();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
